// File: rtl/motor_cmd_slew_if.sv
// Command handshake between the flight controller (master) and the slew stage (slave).
interface motor_cmd_slew_if;
    logic       cmd_valid_in;
    logic [7:0] cmd_in;
    logic       cmd_ready_out;

    modport master (output cmd_valid_in, output cmd_in, input cmd_ready_out);
    modport slave  (input cmd_valid_in, input cmd_in, output cmd_ready_out);
endinterface

// File: rtl/motor_cmd_slew.sv
// Throttle command stage ahead of the PWM generator: one-entry command buffer,
// arming, slew-rate limiting and a command watchdog. Duty only changes on PWM
// period boundaries (tick), except an immediate disarm.
module motor_cmd_slew #(
    parameter int PERIOD_BITS = 8,
    parameter int STEP        = 4,
    parameter int TIMEOUT     = 1024
) (
    input  logic                   clk_in,
    input  logic                   rst_in,
    motor_cmd_slew_if.slave        cmd_if,
    input  logic                   arm_in,
    output logic [7:0]             duty_out,
    output logic                   update_out,
    output logic                   armed_out,
    output logic                   failsafe_out
);
    localparam int WD_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {S_DIS, S_ARM, S_FS} state_t;

    state_t                 r_state, w_state_nxt;
    logic [PERIOD_BITS-1:0] r_cnt;
    logic                   r_pending;
    logic [7:0]             r_pend_val;
    logic [7:0]             r_target;
    logic [7:0]             r_duty;
    logic [WD_W-1:0]        r_wd;
    logic                   r_update;

    logic                   w_tick;
    logic                   w_accept;
    logic                   w_disarm;
    logic [7:0]             w_tgt_nxt;
    logic [WD_W-1:0]        w_wd_nxt;
    logic [7:0]             w_duty_nxt;
    logic [8:0]             w_up, w_tgt_pls;

    assign w_tick   = &r_cnt;
    assign cmd_if.cmd_ready_out = !r_pending;
    assign w_accept = cmd_if.cmd_valid_in & !r_pending;
    // Dropping arm leaves ARMED/FAILSAFE at once, ahead of everything else
    assign w_disarm = (r_state != S_DIS) && !arm_in;

    // Target and watchdog as they will be after this tick's buffer load
    always_comb begin
        w_tgt_nxt = r_pending ? r_pend_val : r_target;
        if (r_state == S_FS)
            w_tgt_nxt = 8'd0;
        if (r_pending)
            w_wd_nxt = '0;
        else if (r_wd == WD_W'(TIMEOUT))
            w_wd_nxt = r_wd;
        else
            w_wd_nxt = r_wd + 1'b1;
    end

    // Slew arithmetic in 9 bits so duty never wraps past 0 or 255
    assign w_up      = {1'b0, r_duty} + 9'(STEP);
    assign w_tgt_pls = {1'b0, w_tgt_nxt} + 9'(STEP);

    // Duty value to present after a tick
    always_comb begin
        w_duty_nxt = r_duty;
        case (r_state)
            S_ARM: begin
                if (w_tgt_nxt > r_duty)
                    w_duty_nxt = (w_up >= {1'b0, w_tgt_nxt}) ? w_tgt_nxt : w_up[7:0];
                else
                    w_duty_nxt = (w_tgt_pls >= {1'b0, r_duty}) ? w_tgt_nxt : r_duty - 8'(STEP);
            end
            S_FS:    w_duty_nxt = ({1'b0, r_duty} <= 9'(STEP)) ? 8'd0 : r_duty - 8'(STEP);
            default: w_duty_nxt = 8'd0;
        endcase
    end

    // State register
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) r_state <= S_DIS;
        else        r_state <= w_state_nxt;
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        if (w_disarm)
            w_state_nxt = S_DIS;
        else if (w_tick) begin
            case (r_state)
                S_DIS:   if (arm_in && w_tgt_nxt == 8'd0) w_state_nxt = S_ARM;
                S_ARM:   if (w_wd_nxt == WD_W'(TIMEOUT)) w_state_nxt = S_FS;
                S_FS:    if (r_duty == 8'd0) w_state_nxt = S_DIS;
                default: w_state_nxt = S_DIS;
            endcase
        end
    end

    // State-decoded outputs
    always_comb begin
        armed_out    = (r_state != S_DIS);
        failsafe_out = (r_state == S_FS);
    end

    // Period counter, command buffer, target, watchdog and duty datapath
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_cnt      <= '0;
            r_pending  <= 1'b0;
            r_pend_val <= 8'd0;
            r_target   <= 8'd0;
            r_duty     <= 8'd0;
            r_wd       <= '0;
            r_update   <= 1'b0;
        end else begin
            r_cnt    <= r_cnt + PERIOD_BITS'(1);
            r_update <= 1'b0;
            if (w_disarm) begin
                r_duty    <= 8'd0;
                r_update  <= 1'b1;
                r_target  <= 8'd0;
                r_pending <= 1'b0;
                r_wd      <= '0;
            end else begin
                if (w_tick) begin
                    r_target  <= w_tgt_nxt;
                    r_wd      <= w_wd_nxt;
                    r_duty    <= w_duty_nxt;
                    r_update  <= (w_duty_nxt != r_duty);
                    r_pending <= 1'b0;
                end
                // Only possible when the buffer was empty, so never collides with the tick load
                if (w_accept) begin
                    r_pending  <= 1'b1;
                    r_pend_val <= cmd_if.cmd_in;
                end
            end
        end
    end

    assign duty_out   = r_duty;
    assign update_out = r_update;
endmodule
